name_rom_arbiter: RTL and testbench
===================================

# name_rom_arbiter

Shares the single-port name-banner sprite ROM (356×12 pixels, 8-bit pixels, 4272 words, one-cycle registered read) between two requesters. The VGA display fetch path has absolute priority; an auxiliary port (collision checker, text-blink effect) is served only in cycles the display leaves idle. The block converts (x, y) pixel coordinates into linear ROM addresses, tracks in-flight reads through a tag pipeline, and routes returned data back to the requester that issued the read.

## Interface
- IMG_W, 356, sprite width in pixels
- IMG_H, 12, sprite height in pixels
- ADDR_W, 13, ROM address width
- DATA_W, 8, pixel width
- i_clk2  in  1  pixel clock, shared with the ROM
- i_rst  in  1  synchronous, active-high reset
- i_disp_req  in  1  display fetch request, one pixel per cycle
- i_disp_x  in  9  display x coordinate, 0..IMG_W-1
- i_disp_y  in  4  display y coordinate, 0..IMG_H-1
- o_disp_data  out  DATA_W  pixel returned to the display
- o_disp_valid  out  1  o_disp_data valid, one-cycle pulse per request
- i_aux_req  in  1  aux request level; x/y held stable until o_aux_gnt
- i_aux_x  in  9  aux x coordinate
- i_aux_y  in  4  aux y coordinate
- o_aux_gnt  out  1  one-cycle pulse: aux request accepted
- o_aux_data  out  DATA_W  pixel returned to aux
- o_aux_valid  out  1  o_aux_data valid, one-cycle pulse
- o_rom_addr  out  ADDR_W  registered address to the ROM
- i_rom_data  in  DATA_W  ROM read data, one cycle after o_rom_addr

## Operation
- Address: addr = y*356 + x, computed as (y<<8)+(y<<6)+(y<<5)+(y<<2)+x in ADDR_W bits; max 11*356+355 = 4271.
- Arbitration per cycle: i_disp_req high → display issued; else aux issued if the aux FSM is A_IDLE and i_aux_req high; else no issue, o_rom_addr holds its previous value.
- Aux FSM: A_IDLE → A_BUSY on issue (o_aux_gnt pulses the same cycle the address registers); A_BUSY → A_IDLE in the cycle o_aux_valid is asserted. i_aux_req is ignored in A_BUSY. If still high in A_IDLE, it is a new request.
- Tag pipeline: 2-stage shift register carrying {valid, owner, oob} alongside the address and ROM stages. Returned data is steered by owner; the non-owner valid stays low.
- Output registers: o_disp_data / o_aux_data hold their last value when not valid.
- Reset values: o_rom_addr = 0, o_disp_data = 0, o_aux_data = 0, o_disp_valid = 0, o_aux_valid = 0, o_aux_gnt = 0, tags cleared, FSM = A_IDLE.
- Reset mid-operation: in-flight reads are discarded and no valid pulse is produced for them. The aux requester must re-request.

## Timing
- Request sampled at the rising edge ending cycle C. o_rom_addr is valid in C+1. ROM data arrives in C+2. o_*_data/o_*_valid are registered and valid in C+3. Fixed 3-cycle latency for both owners.
- Display throughput: 1 pixel/cycle, never stalled. Back-to-back requests produce back-to-back valids in order.
- o_aux_gnt is asserted in C+1, coincident with o_rom_addr.
- Aux worst-case wait is unbounded while i_disp_req is continuously high. This is by design; aux is served during blanking.
- Simultaneous display and aux request: the display is issued, no o_aux_gnt is given, and aux stays pending.

## Configuration
- NAME_ROM_BOUNDS_EN defined: coordinates with x ≥ IMG_W or y ≥ IMG_H set the oob tag. o_rom_addr is not updated, and the returned data is forced to 8'h00 (transparent) with normal valid and latency. The aux FSM and handshake behave identically.
- NAME_ROM_BOUNDS_EN undefined: there is no check. The address is computed blindly and truncated to ADDR_W, and data for addresses ≥ 4272 is undefined (X in simulation).

## Test plan
- Display (0,0), (10,2), (355,11) on consecutive cycles → o_rom_addr 0, 722, 4271 in successive cycles. o_disp_valid is high for 3 consecutive cycles starting 3 cycles after the first request, with data matching the ROM image words.
- Aux-only request (5,1) with the display idle → o_aux_gnt pulses 1 cycle later, o_rom_addr = 361, o_aux_valid 3 cycles after the request with ROM[361]. A held i_aux_req re-issues only after o_aux_valid.
- Display and aux requesting together for 4 cycles, then display drops → no o_aux_gnt for the 4 cycles. The grant arrives in the first display-idle cycle, and all 4 display pixels return in order.
- With NAME_ROM_BOUNDS_EN: display (356,0) and aux (0,12) → o_disp_data = 0x00 and o_aux_data = 0x00 with valid at normal latency, and o_rom_addr is unchanged.
- i_rst asserted 1 cycle after issuing display (20,3) and aux → no valid pulses afterward, all outputs 0, FSM in A_IDLE. A new aux request after reset is granted normally.
- Reset release with no requests for 10 cycles → all valids and o_aux_gnt stay 0, and o_rom_addr stays 0.

Source files
------------

// File: rtl/name_rom_arbiter_if.sv
// Bus bundle between the name-banner ROM arbiter, its two requesters and the sprite ROM.
// The slave modport is the arbiter side; the master modport is the requester/ROM side.
interface name_rom_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              i_disp_req;
  logic [8:0]        i_disp_x;
  logic [3:0]        i_disp_y;
  logic [DATA_W-1:0] o_disp_data;
  logic              o_disp_valid;

  logic              i_aux_req;
  logic [8:0]        i_aux_x;
  logic [3:0]        i_aux_y;
  logic              o_aux_gnt;
  logic [DATA_W-1:0] o_aux_data;
  logic              o_aux_valid;

  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;

  modport slave (
    input  i_disp_req, i_disp_x, i_disp_y,
    output o_disp_data, o_disp_valid,
    input  i_aux_req, i_aux_x, i_aux_y,
    output o_aux_gnt, o_aux_data, o_aux_valid,
    output o_rom_addr,
    input  i_rom_data
  );

  modport master (
    output i_disp_req, i_disp_x, i_disp_y,
    input  o_disp_data, o_disp_valid,
    output i_aux_req, i_aux_x, i_aux_y,
    input  o_aux_gnt, o_aux_data, o_aux_valid,
    input  o_rom_addr,
    output i_rom_data
  );
endinterface

// File: rtl/name_rom_arbiter.sv
// Shares the single-port name-banner sprite ROM between the display fetch (absolute priority)
// and an aux requester. Optional bounds checking is enabled by defining NAME_ROM_BOUNDS_EN.
//
// state  | meaning
// A_IDLE | no aux read in flight; a high i_aux_req may be issued when the display is idle
// A_BUSY | aux read in flight; i_aux_req ignored until o_aux_valid
module name_rom_arbiter #(
  parameter int IMG_W  = 356,
  parameter int IMG_H  = 12,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic i_clk2,
  input  logic i_rst,
  name_rom_arbiter_if.slave bus
);

  localparam int SUM_W = ADDR_W + 3;

  // The shift-add address decomposition below is hard-wired for a 356-wide image.
  if (IMG_W != 356) begin : g_bad_width
    $error("name_rom_arbiter: address decomposition assumes IMG_W == 356");
  end
  if (IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("name_rom_arbiter: ADDR_W too narrow for IMG_W*IMG_H");
  end

  typedef enum logic {A_IDLE = 1'b0, A_BUSY = 1'b1} aux_state_t;

  typedef struct packed {
    logic valid;
    logic owner;   // 1 = aux, 0 = display
    logic oob;
  } tag_t;

  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [8:0] x, input logic [3:0] y);
    logic [SUM_W-1:0] yw;
    logic [SUM_W-1:0] xw;
    logic [SUM_W-1:0] sum;
    yw  = {{(SUM_W-4){1'b0}}, y};
    xw  = {{(SUM_W-9){1'b0}}, x};
    sum = (yw << 8) + (yw << 6) + (yw << 5) + (yw << 2) + xw;
    return sum[ADDR_W-1:0];
  endfunction

`ifdef NAME_ROM_BOUNDS_EN
  localparam logic [8:0] IMG_W_C = 9'(IMG_W);
  localparam logic [3:0] IMG_H_C = 4'(IMG_H);

  function automatic logic is_oob(input logic [8:0] x, input logic [3:0] y);
    return (x >= IMG_W_C) || (y >= IMG_H_C);
  endfunction
`else
  function automatic logic is_oob(input logic [8:0] x, input logic [3:0] y);
    return 1'b0 & (|x) & (|y);
  endfunction
`endif

  aux_state_t        aux_state_q, aux_state_d;
  tag_t              tag_s1, tag_s2;
  logic              disp_issue, aux_issue, any_issue;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oob;
  logic [DATA_W-1:0] ret_data;

  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] disp_data_q, aux_data_q;
  logic              disp_valid_q, aux_valid_q, aux_gnt_q;

  always_ff @(posedge i_clk2) begin
    if (i_rst) aux_state_q <= A_IDLE;
    else       aux_state_q <= aux_state_d;
  end

  always_comb begin
    aux_state_d = aux_state_q;
    case (aux_state_q)
      A_IDLE: if (aux_issue) aux_state_d = A_BUSY;
      A_BUSY: if (tag_s2.valid && tag_s2.owner) aux_state_d = A_IDLE;
      default: aux_state_d = A_IDLE;
    endcase
  end

  always_comb begin
    disp_issue = bus.i_disp_req;
    aux_issue  = !bus.i_disp_req && (aux_state_q == A_IDLE) && bus.i_aux_req;
    any_issue  = disp_issue || aux_issue;
    sel_addr   = rom_addr_q;
    sel_oob    = 1'b0;
    if (disp_issue) begin
      sel_addr = xy_to_addr(bus.i_disp_x, bus.i_disp_y);
      sel_oob  = is_oob(bus.i_disp_x, bus.i_disp_y);
    end else if (aux_issue) begin
      sel_addr = xy_to_addr(bus.i_aux_x, bus.i_aux_y);
      sel_oob  = is_oob(bus.i_aux_x, bus.i_aux_y);
    end
  end

  // Out-of-bounds reads return transparent pixels at the normal latency.
  assign ret_data = tag_s2.oob ? '0 : bus.i_rom_data;

  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      tag_s1       <= '0;
      tag_s2       <= '0;
      rom_addr_q   <= '0;
      aux_gnt_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      aux_valid_q  <= 1'b0;
      disp_data_q  <= '0;
      aux_data_q   <= '0;
    end else begin
      tag_s1       <= '{valid: any_issue, owner: aux_issue, oob: sel_oob};
      tag_s2       <= tag_s1;
      if (any_issue && !sel_oob) rom_addr_q <= sel_addr;
      aux_gnt_q    <= aux_issue;
      disp_valid_q <= tag_s2.valid && !tag_s2.owner;
      aux_valid_q  <= tag_s2.valid && tag_s2.owner;
      if (tag_s2.valid) begin
        if (tag_s2.owner) aux_data_q  <= ret_data;
        else              disp_data_q <= ret_data;
      end
    end
  end

  assign bus.o_rom_addr   = rom_addr_q;
  assign bus.o_aux_gnt    = aux_gnt_q;
  assign bus.o_disp_valid = disp_valid_q;
  assign bus.o_disp_data  = disp_data_q;
  assign bus.o_aux_valid  = aux_valid_q;
  assign bus.o_aux_data   = aux_data_q;

endmodule

// File: tb/tb_name_rom_arbiter.sv
// Directed bench for name_rom_arbiter with a registered behavioural sprite ROM.
// Bounds-check vectors run only when NAME_ROM_BOUNDS_EN is defined.
module tb_name_rom_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] rom_q = 8'h00;

  always #5 clk = ~clk;

  name_rom_arbiter_if #(.ADDR_W(13), .DATA_W(8)) bus ();

  name_rom_arbiter #(.IMG_W(356), .IMG_H(12), .ADDR_W(13), .DATA_W(8)) dut (
    .i_clk2 (clk),
    .i_rst  (rst),
    .bus    (bus)
  );

  function automatic logic [7:0] rom_word(input logic [12:0] a);
    logic [31:0] t;
    t = {19'd0, a} * 32'd37 + 32'd11;
    return t[7:0];
  endfunction

  always @(posedge clk) rom_q <= rom_word(bus.o_rom_addr);
  assign bus.i_rom_data = rom_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic req, input int x, input int y);
    bus.i_disp_req = req;
    bus.i_disp_x   = 9'(x);
    bus.i_disp_y   = 4'(y);
  endtask

  task automatic drive_aux(input logic req, input int x, input int y);
    bus.i_aux_req = req;
    bus.i_aux_x   = 9'(x);
    bus.i_aux_y   = 4'(y);
  endtask

  initial begin
    rst = 1'b1;
    drive_disp(1'b0, 0, 0);
    drive_aux(1'b0, 0, 0);
    tick;
    tick;
    rst = 1'b0;

    // reset state
    chk("rst_addr", bus.o_rom_addr, 0);
    chk("rst_disp_data", bus.o_disp_data, 0);
    chk("rst_aux_data", bus.o_aux_data, 0);
    chk("rst_disp_valid", bus.o_disp_valid, 0);
    chk("rst_aux_valid", bus.o_aux_valid, 0);
    chk("rst_aux_gnt", bus.o_aux_gnt, 0);

    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_flags", {bus.o_disp_valid, bus.o_aux_valid, bus.o_aux_gnt}, 0);
      chk("idle_addr", bus.o_rom_addr, 0);
    end

    // display burst (0,0) (10,2) (355,11)
    drive_disp(1'b1, 0, 0);
    tick;
    chk("disp_addr0", bus.o_rom_addr, 0);
    drive_disp(1'b1, 10, 2);
    tick;
    chk("disp_addr1", bus.o_rom_addr, 722);
    chk("disp_early_valid", bus.o_disp_valid, 0);
    drive_disp(1'b1, 355, 11);
    tick;
    chk("disp_addr2", bus.o_rom_addr, 4271);
    chk("disp_valid0", bus.o_disp_valid, 1);
    chk("disp_data0", bus.o_disp_data, rom_word(13'd0));
    drive_disp(1'b0, 0, 0);
    tick;
    chk("disp_valid1", bus.o_disp_valid, 1);
    chk("disp_data1", bus.o_disp_data, rom_word(13'd722));
    chk("disp_no_aux", bus.o_aux_valid, 0);
    tick;
    chk("disp_valid2", bus.o_disp_valid, 1);
    chk("disp_data2", bus.o_disp_data, rom_word(13'd4271));
    tick;
    chk("disp_valid_end", bus.o_disp_valid, 0);
    chk("disp_data_hold", bus.o_disp_data, rom_word(13'd4271));
    tick;

    // aux-only (5,1), held to show re-issue only after o_aux_valid
    drive_aux(1'b1, 5, 1);
    tick;
    chk("aux_gnt", bus.o_aux_gnt, 1);
    chk("aux_addr", bus.o_rom_addr, 361);
    tick;
    chk("aux_busy_gnt_a", bus.o_aux_gnt, 0);
    tick;
    chk("aux_busy_gnt_b", bus.o_aux_gnt, 0);
    chk("aux_valid", bus.o_aux_valid, 1);
    chk("aux_data", bus.o_aux_data, rom_word(13'd361));
    chk("aux_no_disp", bus.o_disp_valid, 0);
    tick;
    chk("aux_regnt", bus.o_aux_gnt, 1);
    chk("aux_valid_pulse", bus.o_aux_valid, 0);
    drive_aux(1'b0, 0, 0);
    tick;
    tick;
    chk("aux_valid2", bus.o_aux_valid, 1);
    tick;
    tick;
    chk("aux_idle_gnt", bus.o_aux_gnt, 0);

    // contention: display (1..4,0) for 4 cycles with aux (7,3) pending
    for (int c = 0; c < 9; c++) begin
      int n;
      drive_disp(c < 4, c + 1, 0);
      drive_aux(c < 5, 7, 3);
      tick;
      n = c + 1;
      chk("cont_gnt", bus.o_aux_gnt, (n == 5) ? 1 : 0);
      chk("cont_disp_valid", bus.o_disp_valid, (n >= 3 && n <= 6) ? 1 : 0);
      if (n >= 3 && n <= 6) chk("cont_disp_data", bus.o_disp_data, rom_word(13'(n - 2)));
      if (n == 5) chk("cont_aux_addr", bus.o_rom_addr, 1075);
      chk("cont_aux_valid", bus.o_aux_valid, (n == 7) ? 1 : 0);
      if (n == 7) chk("cont_aux_data", bus.o_aux_data, rom_word(13'd1075));
    end
    drive_disp(1'b0, 0, 0);
    drive_aux(1'b0, 0, 0);
    tick;

`ifdef NAME_ROM_BOUNDS_EN
    // out-of-range coordinates return transparent pixels, address untouched
    drive_disp(1'b1, 356, 0);
    tick;
    chk("oob_disp_addr", bus.o_rom_addr, 1075);
    drive_disp(1'b0, 0, 0);
    drive_aux(1'b1, 0, 12);
    tick;
    chk("oob_aux_gnt", bus.o_aux_gnt, 1);
    chk("oob_aux_addr", bus.o_rom_addr, 1075);
    drive_aux(1'b0, 0, 0);
    tick;
    chk("oob_disp_valid", bus.o_disp_valid, 1);
    chk("oob_disp_data", bus.o_disp_data, 0);
    tick;
    chk("oob_aux_valid", bus.o_aux_valid, 1);
    chk("oob_aux_data", bus.o_aux_data, 0);
    tick;
    tick;
`endif

    // reset with display (20,3) and aux (2,0) in flight
    drive_disp(1'b1, 20, 3);
    tick;
    chk("mid_disp_addr", bus.o_rom_addr, 1088);
    drive_disp(1'b0, 0, 0);
    drive_aux(1'b1, 2, 0);
    tick;
    chk("mid_aux_gnt", bus.o_aux_gnt, 1);
    rst = 1'b1;
    drive_aux(1'b0, 0, 0);
    tick;
    rst = 1'b0;
    chk("mid_rst_addr", bus.o_rom_addr, 0);
    chk("mid_rst_disp_data", bus.o_disp_data, 0);
    chk("mid_rst_aux_data", bus.o_aux_data, 0);
    chk("mid_rst_gnt", bus.o_aux_gnt, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_valids", {bus.o_disp_valid, bus.o_aux_valid}, 0);
      tick;
    end

    drive_aux(1'b1, 5, 1);
    tick;
    chk("post_rst_gnt", bus.o_aux_gnt, 1);
    chk("post_rst_addr", bus.o_rom_addr, 361);
    drive_aux(1'b0, 0, 0);
    tick;
    tick;
    chk("post_rst_valid", bus.o_aux_valid, 1);
    chk("post_rst_data", bus.o_aux_data, rom_word(13'd361));
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
